// File: rtl/pkt_mux_rr_n.sv
// ---------------------------------------------------------------------------
// pkt_mux_rr_n
//
// Packet-granular N-input Avalon-ST multiplexer. One input is granted at a
// time and keeps the grant until its eop beat is accepted, so beats from
// different inputs never interleave. Arbitration is round-robin
// (ARB_MODE=0) or fixed priority with the lowest index winning (ARB_MODE=1).
// The output is a single register stage that can drain and reload in the
// same cycle, giving one beat per cycle inside a packet.
//
// Parameters:
//   NUM_IN   number of input channels (2..16)
//   DATA_W   data width in bits, multiple of 8
//   EMPTY_W  width of the empty byte count
//   CH_W     width of the channel ID
//   ARB_MODE 0 = round-robin, 1 = fixed priority
//
// Ports:
//   Clk, Rst        clock, asynchronous active-high reset
//   in_valid/ready  per-input handshake
//   in_data         input i at [i*DATA_W +: DATA_W]
//   in_sop/eop      per-input packet delimiters
//   in_empty        input i at [i*EMPTY_W +: EMPTY_W], valid on eop
//   out_*           registered output beat and handshake
//   out_channel     index of the input that sourced the current beat
//   stat_pkt_cnt    per-input 32-bit forwarded packet counts
//
// Optional feature macro: PKT_MUX_STATS_EN builds the per-input packet
// counters; without it stat_pkt_cnt is tied to 0.
// ---------------------------------------------------------------------------
module pkt_mux_rr_n #(
  parameter int NUM_IN   = 4,
  parameter int DATA_W   = 512,
  parameter int EMPTY_W  = $clog2(DATA_W / 8),
  parameter int CH_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  parameter int ARB_MODE = 0
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_sop,
  input  logic [NUM_IN-1:0]         in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [CH_W-1:0]           out_channel,
  output logic [NUM_IN*32-1:0]      stat_pkt_cnt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    last_q, last_d;

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0] out_empty_q, out_empty_d;
  logic [CH_W-1:0]    out_channel_q, out_channel_d;

  logic               arb_hi_found;
  logic [CH_W-1:0]    arb_hi_win;
  logic [CH_W-1:0]    arb_lo_win;
  logic [CH_W-1:0]    winner;

  logic               slot_ready;
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_sop;
  logic               sel_eop;
  logic [EMPTY_W-1:0] sel_empty;
  logic               accept;

  // Round-robin is done in two passes: the lowest valid index above last_q
  // wins; if none exists the search has wrapped, so the lowest valid index
  // overall wins. The lowest-overall result is also the fixed-priority pick.
  always_comb begin
    arb_hi_found = 1'b0;
    arb_hi_win   = '0;
    arb_lo_win   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        arb_lo_win = CH_W'(i);
        if (CH_W'(i) > last_q) begin
          arb_hi_found = 1'b1;
          arb_hi_win   = CH_W'(i);
        end
      end
    end
    if (ARB_MODE == 1) begin
      winner = arb_lo_win;
    end else begin
      winner = arb_hi_found ? arb_hi_win : arb_lo_win;
    end
  end

  // Only the granted input may see ready, and only while the output register
  // is empty or being drained this cycle.
  assign slot_ready = (state_q == LOCKED) & (~out_valid_q | out_ready);

  always_comb begin
    in_ready  = '0;
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_empty = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q == CH_W'(i)) begin
        in_ready[i] = slot_ready;
        sel_valid   = in_valid[i];
        sel_data    = in_data[i*DATA_W +: DATA_W];
        sel_sop     = in_sop[i];
        sel_eop     = in_eop[i];
        sel_empty   = in_empty[i*EMPTY_W +: EMPTY_W];
      end
    end
  end

  assign accept = slot_ready & sel_valid;

  // Grant FSM: the arbitration cycle itself never accepts a beat, which is
  // the single bubble between packets.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = winner;
          state_d = LOCKED;
          if (ARB_MODE == 0) begin
            last_d = winner;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a load wins over a drain so back-to-back beats keep
  // out_valid high.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_empty_d   = out_empty_q;
    out_channel_d = out_channel_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_data_d    = sel_data;
      out_sop_d     = sel_sop;
      out_eop_d     = sel_eop;
      out_empty_d   = sel_empty;
      out_channel_d = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_q        <= CH_W'(NUM_IN - 1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      out_channel_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_empty_q   <= out_empty_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_empty   = out_empty_q;
  assign out_channel = out_channel_q;

`ifdef PKT_MUX_STATS_EN
  // Packed so that input i's counter lands on stat_pkt_cnt[i*32 +: 32];
  // the adder wraps naturally at 32 bits.
  logic [NUM_IN-1:0][31:0] pkt_cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pkt_cnt_q <= '0;
    end else if (accept && sel_eop) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
    end
  end

  assign stat_pkt_cnt = pkt_cnt_q;
`else
  assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_mux_rr_n.sv
// ---------------------------------------------------------------------------
// tb_pkt_mux_rr_n
//
// Bench for pkt_mux_rr_n with two instances: dutRr (round-robin) and dutFp
// (fixed priority). Each input has a source queue of beats; each instance
// has a queue of the beats it should emit, in the order the arbitration
// rules predict. Output beats are popped and compared as they handshake.
// ---------------------------------------------------------------------------
module tb_pkt_mux_rr_n;

  localparam int NUM_IN  = 4;
  localparam int DATA_W  = 64;
  localparam int EMPTY_W = 3;
  localparam int CH_W    = 2;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [1:0]  ch;
  } outBeat_t;

  logic                      Clk;
  logic                      rst        [2];
  logic [NUM_IN-1:0]         inValid    [2];
  logic [NUM_IN-1:0]         inReady    [2];
  logic [NUM_IN*DATA_W-1:0]  inData     [2];
  logic [NUM_IN-1:0]         inSop      [2];
  logic [NUM_IN-1:0]         inEop      [2];
  logic [NUM_IN*EMPTY_W-1:0] inEmpty    [2];
  logic                      outValid   [2];
  logic                      outReady   [2];
  logic [DATA_W-1:0]         outData    [2];
  logic                      outSop     [2];
  logic                      outEop     [2];
  logic [EMPTY_W-1:0]        outEmpty   [2];
  logic [CH_W-1:0]           outChannel [2];
  logic [NUM_IN*32-1:0]      statCnt    [2];

  beat_t    srcQ [2][NUM_IN][$];
  outBeat_t expQ [2][$];

  int          compareCount = 0;
  int          mismatchCount = 0;
  int          cycleCnt = 0;
  int          lastEopCycle [2];
  int          outBeatsSeen [2];
  bit          gapCheck     [2];
  bit          prevStalled  [2];
  logic [71:0] prevOut      [2];

  pkt_mux_rr_n #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W), .ARB_MODE(0)
  ) dutRr (
    .Clk(Clk), .Rst(rst[0]),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
    .in_sop(inSop[0]), .in_eop(inEop[0]), .in_empty(inEmpty[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .out_sop(outSop[0]), .out_eop(outEop[0]), .out_empty(outEmpty[0]),
    .out_channel(outChannel[0]), .stat_pkt_cnt(statCnt[0])
  );

  pkt_mux_rr_n #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W), .ARB_MODE(1)
  ) dutFp (
    .Clk(Clk), .Rst(rst[1]),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
    .in_sop(inSop[1]), .in_eop(inEop[1]), .in_empty(inEmpty[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .out_sop(outSop[1]), .out_eop(outEop[1]), .out_empty(outEmpty[1]),
    .out_channel(outChannel[1]), .stat_pkt_cnt(statCnt[1])
  );

  // Free-running clock shared by both instances.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Hard stop in case something upstream of every bounded loop goes wrong.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] makeData(input int ch, input int pkt, input int beat);
    return {16'(ch), 16'(pkt), 16'(beat), 16'hC0DE};
  endfunction

  task automatic sendPacket(input int d, input int ch, input int pkt,
                            input int nBeats, input int emptyVal);
    beat_t b;
    for (int k = 0; k < nBeats; k++) begin
      b.data  = makeData(ch, pkt, k);
      b.sop   = (k == 0);
      b.eop   = (k == nBeats - 1);
      b.empty = b.eop ? 3'(emptyVal) : 3'd0;
      srcQ[d][ch].push_back(b);
    end
  endtask

  task automatic expectPacket(input int d, input int ch, input int pkt,
                              input int nBeats, input int emptyVal);
    outBeat_t o;
    for (int k = 0; k < nBeats; k++) begin
      o.data  = makeData(ch, pkt, k);
      o.sop   = (k == 0);
      o.eop   = (k == nBeats - 1);
      o.empty = o.eop ? 3'(emptyVal) : 3'd0;
      o.ch    = 2'(ch);
      expQ[d].push_back(o);
    end
  endtask

  function automatic int pendingCount();
    int s = 0;
    for (int d = 0; d < 2; d++) begin
      s += expQ[d].size();
      for (int i = 0; i < NUM_IN; i++) s += srcQ[d][i].size();
    end
    return s;
  endfunction

  // One clock cycle: drive inputs just after the rising edge, then sample
  // and score on the falling edge. Handshakes seen at the falling edge are
  // the ones the DUT takes on the next rising edge.
  task automatic applyStimulus(input logic [1:0] rdy);
    beat_t       b;
    outBeat_t    o;
    logic [71:0] cur;
    @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      outReady[d] = rdy[d];
      for (int i = 0; i < NUM_IN; i++) begin
        if (srcQ[d][i].size() != 0) begin
          b = srcQ[d][i][0];
          inValid[d][i]            = 1'b1;
          inData[d][i*DATA_W +: DATA_W]    = b.data;
          inSop[d][i]              = b.sop;
          inEop[d][i]              = b.eop;
          inEmpty[d][i*EMPTY_W +: EMPTY_W] = b.empty;
        end else begin
          inValid[d][i]            = 1'b0;
          inData[d][i*DATA_W +: DATA_W]    = '0;
          inSop[d][i]              = 1'b0;
          inEop[d][i]              = 1'b0;
          inEmpty[d][i*EMPTY_W +: EMPTY_W] = '0;
        end
      end
    end
    @(negedge Clk);
    cycleCnt++;
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        cur = {outValid[d], outData[d], outSop[d], outEop[d], outEmpty[d], outChannel[d]};
        checkOutput($sformatf("readyOneHot%0d", d), 128'($onehot0(inReady[d])), 1);
        if (prevStalled[d]) checkOutput($sformatf("stallHold%0d", d), cur, prevOut[d]);
        if (outValid[d] && !outReady[d])
          checkOutput($sformatf("stallReady%0d", d), inReady[d], 0);
        prevStalled[d] = outValid[d] && !outReady[d];
        prevOut[d]     = cur;
        if (outValid[d] && outReady[d]) begin
          outBeatsSeen[d]++;
          checkOutput($sformatf("beatPending%0d", d), 128'(expQ[d].size() != 0), 1);
          if (expQ[d].size() != 0) begin
            o = expQ[d].pop_front();
            checkOutput($sformatf("beat%0d", d), cur[70:0], o);
          end
        end
        for (int i = 0; i < NUM_IN; i++) begin
          if (inValid[d][i] && inReady[d][i]) begin
            b = srcQ[d][i].pop_front();
            if (gapCheck[d] && b.sop && lastEopCycle[d] >= 0)
              checkOutput($sformatf("arbGap%0d", d), cycleCnt - lastEopCycle[d], 2);
            if (b.eop) lastEopCycle[d] = cycleCnt;
          end
        end
      end
    end
  endtask

  // Run until every source and expected queue is empty, then idle a few
  // cycles so both instances are back in IDLE with an empty output register.
  task automatic drain(input int maxCycles);
    int n = 0;
    while (pendingCount() != 0 && n < maxCycles) begin
      applyStimulus(2'b11);
      n++;
    end
    checkOutput("drainDone", pendingCount(), 0);
    repeat (3) applyStimulus(2'b11);
  endtask

  // Test sequence.
  initial begin
    int n;
    int base;
    for (int d = 0; d < 2; d++) begin
      rst[d]          = 1'b1;
      outReady[d]     = 1'b0;
      inValid[d]      = '0;
      inData[d]       = '0;
      inSop[d]        = '0;
      inEop[d]        = '0;
      inEmpty[d]      = '0;
      lastEopCycle[d] = -1;
      outBeatsSeen[d] = 0;
      gapCheck[d]     = 1'b0;
      prevStalled[d]  = 1'b0;
      prevOut[d]      = '0;
    end
    repeat (2) @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rstValid%0d", d), outValid[d], 0);
      checkOutput($sformatf("rstData%0d", d), outData[d], 0);
      checkOutput($sformatf("rstChannel%0d", d), outChannel[d], 0);
      checkOutput($sformatf("rstReady%0d", d), inReady[d], 0);
      checkOutput($sformatf("rstStat%0d", d), statCnt[d], 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    $display("[TB] round-robin fairness");
    gapCheck[0] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int ch = 0; ch < NUM_IN; ch++) begin
        sendPacket(0, ch, p, 2, ch);
        expectPacket(0, ch, p, 2, ch);
      end
    end
    drain(200);
    gapCheck[0] = 1'b0;

    $display("[TB] single input with latency");
    sendPacket(0, 2, 10, 3, 5);
    expectPacket(0, 2, 10, 3, 5);
    n = 0;
    do begin
      applyStimulus(2'b11);
      n++;
    end while (!outValid[0] && n < 10);
    checkOutput("firstLatency", n - 1, 2);
    drain(50);

    $display("[TB] backpressure");
    sendPacket(0, 3, 20, 4, 7);
    expectPacket(0, 3, 20, 4, 7);
    for (int k = 0; k < 24; k++)
      applyStimulus(((k % 4) == 1 || (k % 4) == 2) ? 2'b10 : 2'b11);
    drain(50);

    $display("[TB] reset mid-packet");
    sendPacket(0, 1, 30, 5, 0);
    expectPacket(0, 1, 30, 5, 0);
    base = outBeatsSeen[0];
    n = 0;
    while ((outBeatsSeen[0] - base) < 2 && n < 20) begin
      applyStimulus(2'b11);
      n++;
    end
    checkOutput("rstBeats", outBeatsSeen[0] - base, 2);
    rst[0] = 1'b1;
    #1;
    checkOutput("midRstValid", outValid[0], 0);
    checkOutput("midRstData", outData[0], 0);
    checkOutput("midRstReady", inReady[0], 0);
    for (int i = 0; i < NUM_IN; i++) srcQ[0][i].delete();
    expQ[0].delete();
    prevStalled[0] = 1'b0;
    repeat (2) applyStimulus(2'b11);
    rst[0] = 1'b0;
    sendPacket(0, 3, 40, 2, 1);
    sendPacket(0, 0, 41, 2, 2);
    expectPacket(0, 0, 41, 2, 2);
    expectPacket(0, 3, 40, 2, 1);
    drain(50);

    $display("[TB] packet counters");
    sendPacket(0, 0, 50, 2, 0);
    sendPacket(0, 0, 51, 1, 4);
    expectPacket(0, 0, 50, 2, 0);
    expectPacket(0, 0, 51, 1, 4);
    drain(50);

    $display("[TB] fixed priority");
    sendPacket(1, 1, 60, 4, 1);
    sendPacket(1, 3, 61, 4, 3);
    expectPacket(1, 1, 60, 4, 1);
    expectPacket(1, 0, 62, 4, 2);
    expectPacket(1, 3, 61, 4, 3);
    n = 0;
    while (!(outValid[1] && outChannel[1] == 2'd1) && n < 20) begin
      applyStimulus(2'b11);
      n++;
    end
    checkOutput("fpLatency", n, 3);
    sendPacket(1, 0, 62, 4, 2);
    drain(80);

`ifdef PKT_MUX_STATS_EN
    checkOutput("statRr0", statCnt[0][0*32 +: 32], 3);
    checkOutput("statRr1", statCnt[0][1*32 +: 32], 0);
    checkOutput("statRr2", statCnt[0][2*32 +: 32], 0);
    checkOutput("statRr3", statCnt[0][3*32 +: 32], 1);
    checkOutput("statFp0", statCnt[1][0*32 +: 32], 1);
    checkOutput("statFp1", statCnt[1][1*32 +: 32], 1);
    checkOutput("statFp2", statCnt[1][2*32 +: 32], 0);
    checkOutput("statFp3", statCnt[1][3*32 +: 32], 1);
`else
    checkOutput("statTiedRr", statCnt[0], 0);
    checkOutput("statTiedFp", statCnt[1], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/pkt_mux_rr_n.md
# pkt_mux_rr_n

Parametrised N-input, packet-granular Avalon-ST multiplexer, the successor to the fixed 2- and 3-input packet muxes. It replaces cascaded mux trees in the ethernet egress path with a single stage that has:

- a configurable data width and channel count;
- a selectable arbitration mode (round-robin or fixed priority);
- a registered output and a channel-ID output.

A grant always covers a whole packet, so beats from different inputs never interleave.

## Interface
Parameters:
- NUM_IN, 4: number of input channels, 2..16.
- DATA_W, 512: data width in bits; must be a multiple of 8.
- EMPTY_W, $clog2(DATA_W/8): width of the empty field.
- CH_W, max(1,$clog2(NUM_IN)): width of the channel ID.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_IN  per-input valid.
- in_ready  out  NUM_IN  per-input ready.
- in_data  in  NUM_IN*DATA_W  input i occupies slice [i*DATA_W +: DATA_W].
- in_sop, in_eop  in  NUM_IN each  per-input start/end of packet.
- in_empty  in  NUM_IN*EMPTY_W  per-input empty byte count, valid on eop.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  output data.
- out_sop, out_eop  out  1 each  output start/end of packet.
- out_empty  out  EMPTY_W  output empty byte count.
- out_channel  out  CH_W  index of the input that sourced the current beat.
- stat_pkt_cnt  out  NUM_IN*32  per-input count of forwarded packets (see Configuration).

## Operation
- FSM states:
  - IDLE: no grant held.
  - LOCKED: a grant is held, stored in register grant_q.
- IDLE, some in_valid set:
  - pick a winner, load it into grant_q, go to LOCKED.
  - No input is accepted in this cycle: all in_ready are 0.
- IDLE, no in_valid set: stay in IDLE.
- Round-robin (ARB_MODE=0):
  - search starts at index last_q+1 and wraps modulo NUM_IN.
  - last_q updates to the winner at grant time.
  - last_q resets to NUM_IN-1, so input 0 has first priority after reset.
- Fixed priority (ARB_MODE=1): the lowest-indexed valid input wins; last_q is unused.
- LOCKED:
  - in_ready[grant_q] = ~out_valid | out_ready; all other in_ready are 0.
  - An input beat is accepted when in_valid[grant_q] & in_ready[grant_q].
  - An accepted beat loads the output register: data, sop, eop, empty, and channel = grant_q.
- LOCKED, accepted beat has eop=1: go to IDLE. This also covers a single-beat packet with sop=eop=1.
- in_sop is not checked. The first beat accepted after a grant is forwarded as it arrives; the block does not repair a missing sop.
- Output register:
  - out_valid sets on an accepted beat.
  - out_valid clears when out_ready=1 and no new beat is accepted in the same cycle.
  - Simultaneous drain and load: out_valid stays 1 and the register takes the new beat. This gives full throughput, one beat per cycle, inside a packet.
- Reset, asserted asynchronously at any time, including mid-packet:
  - State returns to IDLE, last_q to NUM_IN-1, out_valid to 0.
  - out_data, out_sop, out_eop, out_empty and out_channel go to 0.
  - Any partial packet is dropped; the downstream sees a truncated packet with no eop. Recovery is the system's job.

## Timing
- Grant decided in cycle t (state IDLE).
- in_ready for the granted input first high in cycle t+1.
- First beat is visible on out_valid in cycle t+2.
- Latency from an accepted input beat to out_valid is 1 cycle.
- Between packets:
  - eop accepted in cycle e.
  - IDLE in cycle e+1; arbitration happens in e+1.
  - Next packet's first beat is accepted no earlier than e+2.
- out_valid may stay high across a packet boundary while the register drains. Bubbles on the output come only from the arbitration cycle.
- With out_ready held low, out_valid, out_data, out_sop, out_eop, out_empty and out_channel stay stable, and in_ready stays 0.

## Configuration
- PKT_MUX_STATS_EN defined:
  - Each input has a 32-bit counter that increments on an accepted eop beat from that input.
  - The counter wraps from 0xFFFF_FFFF to 0.
  - Counters reset to 0.
  - Input i's count is driven on stat_pkt_cnt[i*32 +: 32].
- PKT_MUX_STATS_EN undefined: no counter logic is built, and stat_pkt_cnt is tied to 0.

## Test plan
- Single input, NUM_IN=4, ARB_MODE=0: input 2 sends a 3-beat packet with empty=5 and out_ready=1. Expect 3 output beats: sop on the first beat, eop with empty=5 on the last, out_channel=2 throughout. First out_valid is 2 cycles after input 2's valid.
- Round-robin fairness, ARB_MODE=0: inputs 0-3 each continuously offer 2-beat packets. Expect output packet order 0,1,2,3,0,1,… with no interleaving of beats, and one idle input-acceptance cycle between packets.
- Fixed priority, ARB_MODE=1: inputs 1 and 3 both valid. Expect input 1's packet first, then input 3's. Inject a new input-0 packet during input 1's packet; expect input 0 to go before input 3.
- Backpressure: toggle out_ready 1,0,0,1 during a 4-beat packet. Expect no beat lost or duplicated, outputs held stable while out_ready=0, and in_ready=0 while out_valid=1 and out_ready=0.
- Reset mid-packet: assert Rst after beat 2 of a 5-beat packet from input 1. Expect out_valid=0 immediately. After release, input 0 is granted first when both inputs are valid.
- Stats (PKT_MUX_STATS_EN): forward 3 packets from input 0 and 1 packet from input 3. Expect stat_pkt_cnt slices 0..3 = 3, 0, 0, 1. Preload counter 0 to 0xFFFF_FFFF, forward one more input-0 packet, and expect counter 0 = 0.
